// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial LSB-first adder with start/done handshake.
// Optional subtract mode (sub port) enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, b_in;
  logic [CW-1:0] cnt;
  logic c, c_in, h, s, c_next, last;
`ifdef SERIAL_ADD_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub;
`else
  assign b_in = b;
  assign c_in = 1'b0;
`endif
  assign h = sa[0] ^ sb[0];
  assign s = h ^ c;
  assign c_next = (sa[0] & sb[0]) | (h & c);
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sa    <= a;
          sb    <= b_in;
          c     <= c_in;
          cnt   <= '0;
          sum   <= '0;
          cout  <= 1'b0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= c_next;
          sum <= {s, sum[WIDTH-1:1]};
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= c_next;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: random and directed checks of serial_add_seq against an arithmetic model.
module tb_serial_add_seq;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [W-1:0] sum;
  int ntests = 0, nfail = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
    logic [W:0] r;
`ifdef SERIAL_ADD_SUB_EN
    r = sb ? ({1'b0, x} + {1'b0, ~y} + (W+1)'(1)) : ({1'b0, x} + {1'b0, y});
`else
    r = {1'b0, x} + {1'b0, y};
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles since the accepting edge, plus the result the outputs must hold.
  int m_cnt;
  logic m_valid;
  logic [W:0] m_res, m_pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_valid = 1'b1; m_res = '0; m_pend = '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt = 1; m_valid = 1'b0; m_pend = ref_result(a, b, sub);
      end
    end else if (m_cnt == W + 1) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == W + 1) begin
        m_valid = 1'b1; m_res = m_pend;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_cnt >= 1 && m_cnt <= W));
    check("done", 32'(done), 32'(m_cnt == W + 1));
    if (m_valid) begin
      check("sum", 32'(sum), 32'(m_res[W-1:0]));
      check("cout", 32'(cout), 32'(m_res[W]));
    end
  end

  // Call just after a posedge while idle; returns at the negedge of the done cycle.
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                     input logic [W-1:0] es, input logic ec);
    int n = 0, bc = 0;
    start = 1'b1; a = ta; b = tb; sub = ts;
    @(posedge clk); #2 start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    while (n < 3 * W) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (done) break;
    end
    check("latency", 32'(n), 32'(W + 1));
    check("busy_cycles", 32'(bc), 32'(W));
    check("res_sum", 32'(sum), 32'(es));
    check("res_cout", 32'(cout), 32'(ec));
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rs;
    int dcnt;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    #1 rst = 1'b0;
    @(posedge clk); #2;
    run(8'h03, 8'h05, 1'b0, 8'h08, 1'b0);
    @(posedge clk); #2;
    run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #2;
    run(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
    // start pulsed again in cycle 4 must be lost
    @(posedge clk); #2;
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1; a = 8'hFF;
    @(posedge clk); #2 start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        check("ignored_start_sum", 32'(sum), 32'h30);
      end
    end
    check("done_pulses", 32'(dcnt), 1);
    // reset mid-operation
    @(posedge clk); #2;
    start = 1'b1; a = 8'h33; b = 8'h44;
    @(posedge clk); #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_sum", 32'(sum), 0);
    check("abort_cout", 32'(cout), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;
    run(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    // back-to-back: second start in first IDLE cycle after done
    @(posedge clk); #2;
    run(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0);
    @(posedge clk); #2;
    check("b2b_hold", 32'(sum), 32'hFF);
    run(8'hC0, 8'h41, 1'b0, 8'h01, 1'b1);
`ifdef SERIAL_ADD_SUB_EN
    @(posedge clk); #2;
    run(8'h05, 8'h03, 1'b1, 8'h02, 1'b1);
    @(posedge clk); #2;
    run(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0);
`endif
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if (i % 5 == 0) rb = W'(-int'(ra));
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      r = ref_result(ra, rb, rs);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2;
      run(ra, rb, rs, r[W-1:0], r[W]);
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
